// File: rtl/mips_pkg.sv
// Shared encodings for the single-cycle MIPS subset: opcodes, R-type functs,
// ALU control codes and the main instruction decoder.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_ctrl_e;

  typedef struct packed {
    logic      reg_write;
    logic      reg_dst;
    logic      alu_src;
    logic      branch;
    logic      mem_write;
    logic      mem_to_reg;
    logic      jump;
    alu_ctrl_e alu_ctrl;
  } ctrl_t;

  // Anything not recognised decodes to a no-op: no writes, PC+4.
  function automatic ctrl_t decode(input logic [5:0] op, input logic [5:0] funct);
    ctrl_t c;
    c = '{default: 1'b0, alu_ctrl: ALU_ADD};
    case (op)
      OP_RTYPE: begin
        c.reg_dst = 1'b1;
        c.reg_write = 1'b1;
        case (funct)
          FN_ADD:  c.alu_ctrl = ALU_ADD;
          FN_SUB:  c.alu_ctrl = ALU_SUB;
          FN_AND:  c.alu_ctrl = ALU_AND;
          FN_OR:   c.alu_ctrl = ALU_OR;
          FN_SLT:  c.alu_ctrl = ALU_SLT;
          default: c.reg_write = 1'b0;
        endcase
      end
      OP_LW: begin
        c.reg_write = 1'b1;
        c.alu_src = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      OP_SW: begin
        c.alu_src = 1'b1;
        c.mem_write = 1'b1;
      end
      OP_BEQ: begin
        c.branch = 1'b1;
        c.alu_ctrl = ALU_SUB;
      end
      OP_ADDI: begin
        c.reg_write = 1'b1;
        c.alu_src = 1'b1;
      end
      OP_J:    c.jump = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mips_core.sv
// Single-cycle core: decoder, register file, ALU and PC update logic.
// The PC is the only state cleared by reset.
module mips_core
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic [31:0] readdata,
  output logic [31:0] pc,
  output logic        memwrite,
  output logic [31:0] aluout,
  output logic [31:0] writedata
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] regs_q [32];
  ctrl_t       ctrl;
  logic [4:0]  rs, rt, rd, wa;
  logic [31:0] simm, rd1, rd2, srcb, result, pc_plus4;
  logic        zero;
  logic        unused_shamt;

  assign rs   = instr[25:21];
  assign rt   = instr[20:16];
  assign rd   = instr[15:11];
  assign simm = {{16{instr[15]}}, instr[15:0]};
  assign ctrl = decode(instr[31:26], instr[5:0]);
  assign unused_shamt = &{1'b0, instr[10:6]};

  // $0 is forced to read zero; its storage is never written.
  assign rd1 = (rs == 5'd0) ? 32'd0 : regs_q[rs];
  assign rd2 = (rt == 5'd0) ? 32'd0 : regs_q[rt];
  assign srcb = ctrl.alu_src ? simm : rd2;

  always_comb begin
    aluout = 32'd0;
    case (ctrl.alu_ctrl)
      ALU_AND: aluout = rd1 & srcb;
      ALU_OR:  aluout = rd1 | srcb;
      ALU_ADD: aluout = rd1 + srcb;
      ALU_SUB: aluout = rd1 - srcb;
      ALU_SLT: aluout = {31'd0, $signed(rd1) < $signed(srcb)};
      default: aluout = 32'd0;
    endcase
  end

  assign zero   = (aluout == 32'd0);
  assign wa     = ctrl.reg_dst ? rd : rt;
  assign result = ctrl.mem_to_reg ? readdata : aluout;

  always_ff @(posedge clk) begin
    if (ctrl.reg_write && (wa != 5'd0)) regs_q[wa] <= result;
  end

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    pc_d = pc_plus4;
    if (ctrl.jump)
      pc_d = {pc_plus4[31:28], instr[25:0], 2'b00};
    else if (ctrl.branch && zero)
      pc_d = pc_plus4 + {simm[29:0], 2'b00};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc_q <= 32'd0;
    else     pc_q <= pc_d;
  end

  assign pc        = pc_q;
  assign memwrite  = ctrl.mem_write;
  assign writedata = rd2;

endmodule

// File: rtl/mips_top.sv
// Processor system: core plus the self-check program ROM and a data RAM.
// Store traffic is visible on the ports for an external monitor.
module mips_top
  import mips_pkg::*;
#(
  parameter int IMEM_WORDS = 64,
  parameter int DMEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] writedata,
  output logic [31:0] dataadr,
  output logic        memwrite
);

  logic [31:0] rom [IMEM_WORDS];
  logic [31:0] dmem [DMEM_WORDS];
  logic [31:0] pc, instr, readdata;
  logic        unused_pc;

  // Program ends by storing the slt result (1) at byte 84, then spins on j.
  always_comb begin
    for (int i = 0; i < IMEM_WORDS; i++) rom[i] = 32'd0;
    rom[0] = 32'h20020005;
    rom[1] = 32'h2003000c;
    rom[2] = 32'h0043202a;
    rom[3] = 32'hac020050;
    rom[4] = 32'h8c050050;
    rom[5] = 32'h10a20001;
    rom[6] = 32'hac030058;
    rom[7] = 32'hac040054;
    rom[8] = 32'h08000008;
  end

  assign instr     = rom[pc[7:2]];
  assign readdata  = dmem[dataadr[7:2]];
  assign unused_pc = &{1'b0, pc[31:8], pc[1:0]};

  always_ff @(posedge clk) begin
    if (memwrite) dmem[dataadr[7:2]] <= writedata;
  end

  mips_core u_core (
    .clk       (clk),
    .rst       (reset),
    .instr     (instr),
    .readdata  (readdata),
    .pc        (pc),
    .memwrite  (memwrite),
    .aluout    (dataadr),
    .writedata (writedata)
  );

endmodule

// File: tb/tb_mips_top.sv
// Directed bench for mips_top: reset values, the (80,5)/(84,1) store sequence,
// the skipped store to 88, the halt loop and an asynchronous mid-run reset.
module tb_mips_top;

  logic        clk;
  logic        reset;
  logic [31:0] writedata;
  logic [31:0] dataadr;
  logic        memwrite;

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] exp_q[$];

  mips_top dut (
    .clk       (clk),
    .reset     (reset),
    .writedata (writedata),
    .dataadr   (dataadr),
    .memwrite  (memwrite)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Watches stores on falling edges for a bounded number of cycles and matches
  // them in order against the expected (address, data) queue.
  task automatic run_program(input string pass);
    logic [63:0] e;
    int n_stores = 0;
    int n_88 = 0;
    exp_q.push_back({32'd80, 32'd5});
    exp_q.push_back({32'd84, 32'd1});
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      if (memwrite === 1'b1) begin
        n_stores++;
        if (dataadr == 32'd88) n_88++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : {32'hFFFF_FFFF, 32'hFFFF_FFFF};
        chk({pass, "_store_addr"}, dataadr, e[63:32]);
        chk({pass, "_store_data"}, writedata, e[31:0]);
      end
    end
    chk({pass, "_store_count"}, n_stores, 32'd2);
    chk({pass, "_no_store_88"}, n_88, 32'd0);
    exp_q.delete();
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      chk({pass, "_halt_pc"}, dut.pc, 32'h20);
      chk({pass, "_halt_memwrite"}, {31'd0, memwrite}, 32'd0);
    end
  endtask

  initial begin
    reset = 1'b1;
    @(negedge clk);
    chk("rst_memwrite", {31'd0, memwrite}, 32'd0);
    chk("rst_dataadr", dataadr, 32'd5);
    chk("rst_pc", dut.pc, 32'd0);
    @(negedge clk);
    chk("rst_memwrite2", {31'd0, memwrite}, 32'd0);
    chk("rst_dataadr2", dataadr, 32'd5);
    #2 reset = 1'b0;

    run_program("run1");
    chk("ram_word80", dut.dmem[20], 32'd5);
    chk("ram_word84", dut.dmem[21], 32'd1);

    // Reset pulse entirely between clock edges must still clear the PC.
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_pc", dut.pc, 32'd0);
    chk("async_rst_dataadr", dataadr, 32'd5);
    chk("async_rst_memwrite", {31'd0, memwrite}, 32'd0);
    #1 reset = 1'b0;

    run_program("run2");
    chk("ram_word84_final", dut.dmem[21], 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
